// File: rtl/pipe_front_ctrl_if.sv
// Front-end control bundle: hazard/branch requests and imem data in,
// PC, IF/ID and ID/EX register contents plus perf counters out.
interface pipe_front_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
);
  logic              pc_write;
  logic              if_id_write;
  logic              control_sel;
  logic              branch_taken;
  logic [XLEN-1:0]   branch_target;
  logic [31:0]       imem_instr;
  logic [CTRL_W-1:0] id_ctrl;

  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   if_id_pc;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic              id_ex_valid;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output pc_write, if_id_write, control_sel, branch_taken, branch_target,
           imem_instr, id_ctrl,
    input  pc, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, id_ex_valid,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  pc_write, if_id_write, control_sel, branch_taken, branch_target,
           imem_instr, id_ctrl,
    output pc, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, id_ex_valid,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_front_ctrl.sv
// PC, IF/ID and ID/EX register ownership for the 5-stage RV32 front end:
// applies flush > stall > advance each cycle and counts bubbles/redirects.
module pipe_front_ctrl #(
  parameter int              XLEN      = 32,
  parameter int              CTRL_W    = 12,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter int              CNT_W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  pipe_front_ctrl_if.slave bus
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   pc_reg, pc_next;
  logic [XLEN-1:0]   if_id_pc_reg, if_id_pc_next;
  logic [31:0]       if_id_instr_reg, if_id_instr_next;
  logic              if_id_valid_reg, if_id_valid_next;
  logic [CTRL_W-1:0] id_ex_ctrl_reg, id_ex_ctrl_next;
  logic              id_ex_valid_reg, id_ex_valid_next;
  logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0]  flush_cnt_reg, flush_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      if_id_pc_reg    <= '0;
      if_id_instr_reg <= NOP_INSTR;
      if_id_valid_reg <= 1'b0;
      id_ex_ctrl_reg  <= '0;
      id_ex_valid_reg <= 1'b0;
      stall_cnt_reg   <= '0;
      flush_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      if_id_pc_reg    <= if_id_pc_next;
      if_id_instr_reg <= if_id_instr_next;
      if_id_valid_reg <= if_id_valid_next;
      id_ex_ctrl_reg  <= id_ex_ctrl_next;
      id_ex_valid_reg <= id_ex_valid_next;
      stall_cnt_reg   <= stall_cnt_next;
      flush_cnt_reg   <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    if_id_pc_next    = if_id_pc_reg;
    if_id_instr_next = if_id_instr_reg;
    if_id_valid_next = if_id_valid_reg;
    id_ex_ctrl_next  = id_ex_ctrl_reg;
    id_ex_valid_next = id_ex_valid_reg;
    stall_cnt_next   = stall_cnt_reg;
    flush_cnt_next   = flush_cnt_reg;

    case (state_reg)
      BOOT: begin
        // One settling cycle after reset: pipeline loads empty, inputs ignored.
        state_next       = RUN;
        pc_next          = RESET_PC;
        if_id_pc_next    = '0;
        if_id_instr_next = NOP_INSTR;
        if_id_valid_next = 1'b0;
        id_ex_ctrl_next  = '0;
        id_ex_valid_next = 1'b0;
      end
      default: begin
        if (bus.branch_taken) begin
          // Redirect squashes both younger stages; stall requests are moot.
          pc_next          = bus.branch_target & ~XLEN'(3);
          if_id_pc_next    = '0;
          if_id_instr_next = NOP_INSTR;
          if_id_valid_next = 1'b0;
          id_ex_ctrl_next  = '0;
          id_ex_valid_next = 1'b0;
          if (flush_cnt_reg != '1)
            flush_cnt_next = flush_cnt_reg + CNT_W'(1);
        end else begin
          if (bus.pc_write)
            pc_next = pc_reg + XLEN'(4);
          if (bus.if_id_write) begin
            if_id_pc_next    = pc_reg;
            if_id_instr_next = bus.imem_instr;
            if_id_valid_next = 1'b1;
          end
          if (bus.control_sel) begin
            id_ex_ctrl_next  = '0;
            id_ex_valid_next = 1'b0;
            if (stall_cnt_reg != '1)
              stall_cnt_next = stall_cnt_reg + CNT_W'(1);
          end else begin
            id_ex_ctrl_next  = bus.id_ctrl;
            id_ex_valid_next = if_id_valid_reg;
          end
        end
      end
    endcase
  end

  assign bus.pc          = pc_reg;
  assign bus.if_id_pc    = if_id_pc_reg;
  assign bus.if_id_instr = if_id_instr_reg;
  assign bus.if_id_valid = if_id_valid_reg;
  assign bus.id_ex_ctrl  = id_ex_ctrl_reg;
  assign bus.id_ex_valid = id_ex_valid_reg;
  assign bus.stall_cnt   = stall_cnt_reg;
  assign bus.flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Directed + randomized bench for pipe_front_ctrl against a cycle-level
// behavioural model of the front-end pipeline (CNT_W=2 to reach saturation).
module tb_pipe_front_ctrl;
  localparam int XLEN    = 32;
  localparam int CTRL_W  = 12;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipe_front_ctrl_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  pipe_front_ctrl #(
    .XLEN(XLEN), .CTRL_W(CTRL_W), .RESET_PC('0),
    .NOP_INSTR(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Combinational instruction memory seen by the fetch stage.
  assign bus.imem_instr = imem_f(bus.pc);

  // Reference model state
  logic [31:0] m_pc, m_ifpc, m_ifinstr;
  int          m_ifv, m_exv, m_exctrl, m_sc, m_fc;
  bit          m_boot;

  task automatic model_reset();
    m_pc = 0; m_ifpc = 0; m_ifinstr = NOP; m_ifv = 0;
    m_exctrl = 0; m_exv = 0; m_sc = 0; m_fc = 0; m_boot = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},          bus.pc,                   m_pc);
    chk({tag, ".if_id_pc"},    bus.if_id_pc,             m_ifpc);
    chk({tag, ".if_id_instr"}, bus.if_id_instr,          m_ifinstr);
    chk({tag, ".if_id_valid"}, 32'(bus.if_id_valid),     32'(m_ifv));
    chk({tag, ".id_ex_ctrl"},  32'(bus.id_ex_ctrl),      32'(m_exctrl));
    chk({tag, ".id_ex_valid"}, 32'(bus.id_ex_valid),     32'(m_exv));
    chk({tag, ".stall_cnt"},   32'(bus.stall_cnt),       32'(m_sc));
    chk({tag, ".flush_cnt"},   32'(bus.flush_cnt),       32'(m_fc));
  endtask

  // Drive one cycle's inputs (called just after a negedge), advance the model,
  // then compare after the following negedge.
  task automatic step(input string tag, input bit pw, input bit iw, input bit cs,
                      input bit bt, input logic [31:0] tgt, input int idc);
    logic [31:0] fetched;
    bus.pc_write = pw; bus.if_id_write = iw; bus.control_sel = cs;
    bus.branch_taken = bt; bus.branch_target = tgt; bus.id_ctrl = CTRL_W'(idc);
    fetched = imem_f(m_pc);
    if (m_boot) begin
      m_boot = 0;
      m_pc = 0; m_ifpc = 0; m_ifinstr = NOP; m_ifv = 0; m_exctrl = 0; m_exv = 0;
    end else if (bt) begin
      m_pc = tgt - (tgt % 4);
      m_ifpc = 0; m_ifinstr = NOP; m_ifv = 0; m_exctrl = 0; m_exv = 0;
      m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : CNT_MAX;
    end else begin
      int old_ifv = m_ifv;
      logic [31:0] old_pc = m_pc;
      if (pw) m_pc = 32'((64'(old_pc) + 4) % 64'h1_0000_0000);
      if (iw) begin m_ifpc = old_pc; m_ifinstr = fetched; m_ifv = 1; end
      if (cs) begin
        m_exctrl = 0; m_exv = 0;
        m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : CNT_MAX;
      end else begin
        m_exctrl = idc; m_exv = old_ifv;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    bus.pc_write = 1; bus.if_id_write = 1; bus.control_sel = 0;
    bus.branch_taken = 0; bus.branch_target = '0; bus.id_ctrl = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Reset release and straight-line fetch
    step("boot", 1, 1, 0, 0, 0, 12'h111);
    chk("boot_pc", bus.pc, 32'h0);
    for (int i = 0; i < 4; i++) step("run", 1, 1, 0, 0, 0, 12'h100 + i);
    chk("run_pc", bus.pc, 32'h10);
    chk("run_if_id_pc", bus.if_id_pc, 32'hC);

    // Load-use stall at pc=0x10
    step("stall", 0, 0, 1, 0, 0, 12'hABC);
    chk("stall_pc_hold", bus.pc, 32'h10);
    chk("stall_cnt1", 32'(bus.stall_cnt), 32'd1);
    step("post_stall", 1, 1, 0, 0, 0, 12'h5A5);
    chk("post_stall_pc", bus.pc, 32'h14);

    // Branch together with a bubble request
    step("branch_stall", 0, 0, 1, 1, 32'h103, 12'hFFF);
    chk("branch_pc", bus.pc, 32'h100);
    chk("branch_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    chk("branch_stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // PC wrap
    step("to_top", 1, 1, 0, 1, 32'hFFFF_FFFF, 12'h0);
    step("wrap", 1, 1, 0, 0, 0, 12'h321);
    chk("wrap_pc", bus.pc, 32'h0);

    // Stall counter saturation
    for (int i = 0; i < 5; i++) step("sat", 1, 1, 1, 0, 0, 12'h7);
    chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'd3);

    // Independent combinations of the hazard controls, randomized
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
           $urandom, int'($urandom_range(0, 4095)));
    end

    // Async reset mid-stall with pc=0x40
    step("to_40", 1, 1, 0, 1, 32'h40, 12'h0);
    bus.pc_write = 0; bus.if_id_write = 0; bus.control_sel = 1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    check_all("async_rst_held");
    rst = 1'b0;

    // BOOT ignores a redirect; RUN resumes afterwards
    step("boot2", 0, 0, 1, 1, 32'h200, 12'h9);
    step("run2", 1, 1, 0, 0, 0, 12'h9);
    chk("run2_pc", bus.pc, 32'h4);
    for (int i = 0; i < 20; i++) begin
      step("rand2", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
           $urandom, int'($urandom_range(0, 4095)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_front_ctrl.md
Name: pipe_front_ctrl

Overview:
Front-end pipeline control for the 5-stage RV32 core. It is the consumer of the load-use stall signals (pc_write, if_id_write, control_sel) and of EX-stage branch redirects. It owns the PC register, the IF/ID pipeline register and the ID/EX control register. It applies hold, bubble and flush cycle by cycle, and keeps saturating stall and flush counters for SQED/perf checks.

Parameters:
XLEN, 32, PC / address width
CTRL_W, 12, width of decoded control bundle passed ID->EX
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, instruction loaded into IF/ID on reset/flush (addi x0,x0,0)
CNT_W, 16, width of stall/flush counters

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous reset, active-high
pc_write  in  1  0 = hold PC this cycle (from hazard detection)
if_id_write  in  1  0 = hold IF/ID this cycle
control_sel  in  1  1 = inject bubble (zero control) into ID/EX
branch_taken  in  1  EX-stage redirect request
branch_target  in  XLEN  redirect address
imem_instr  in  32  instruction read at current pc (combinational imem)
id_ctrl  in  CTRL_W  decoded control bundle for instr in IF/ID
pc  out  XLEN  current fetch address
if_id_pc  out  XLEN  PC of instruction in IF/ID
if_id_instr  out  32  instruction in IF/ID
if_id_valid  out  1  IF/ID holds a real instruction
id_ex_ctrl  out  CTRL_W  control bundle in ID/EX
id_ex_valid  out  1  ID/EX holds a real instruction
stall_cnt  out  CNT_W  cycles with bubble injected
flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Reset (async, immediate on rst=1): pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, id_ex_ctrl=0, id_ex_valid=0, stall_cnt=0, flush_cnt=0, state=BOOT.
- FSM, 2 states:
  - BOOT: exactly one cycle after rst deasserts. pc holds RESET_PC; IF/ID loads NOP with valid=0; ID/EX loads 0 with valid=0; all inputs ignored; then -> RUN.
  - RUN: stays in RUN until reset.
- RUN per-cycle priority, all updates on posedge clk: FLUSH > STALL > ADVANCE.
  - FLUSH (branch_taken=1):
    - pc <= {branch_target[XLEN-1:2],2'b00}
    - IF/ID <= {0, NOP_INSTR}, valid 0
    - id_ex_ctrl <= 0, id_ex_valid <= 0
    - flush_cnt +1, saturating at all-ones
    - stall inputs ignored; stall_cnt unchanged.
  - PC update when not flushing:
    - pc_write=1: pc <= pc+4, wrapping mod 2^XLEN
    - pc_write=0: pc holds.
  - IF/ID update when not flushing:
    - if_id_write=1: if_id_pc <= pc, if_id_instr <= imem_instr, if_id_valid <= 1
    - if_id_write=0: IF/ID holds all three fields.
  - ID/EX update when not flushing:
    - control_sel=1: id_ex_ctrl <= 0, id_ex_valid <= 0, stall_cnt +1 saturating
    - control_sel=0: id_ex_ctrl <= id_ctrl, id_ex_valid <= if_id_valid.
- pc_write, if_id_write and control_sel are decoded independently. Any combination is legal and is applied literally (e.g. pc_write=0 with if_id_write=1 re-fetches the same pc).
- Latency: every registered output reflects inputs of the previous edge. No combinational input->output path.
- Counters never wrap. At 2^CNT_W-1 they hold.
- Reset mid-stall or mid-flush: all state returns to reset values asynchronously. The following cycle is BOOT.

Test Plan:
- Reset release, RESET_PC=0, no stalls, imem_instr=pc-dependent pattern -> cycle1 BOOT: pc=0, if_id_valid=0. Cycles 2..4: pc=4,8,12, if_id_pc=0,4,8, if_id_valid=1 from cycle 2, id_ex_valid=1 from cycle 3.
- Load-use stall: pc_write=0, if_id_write=0, control_sel=1 for one cycle at pc=0x10 -> pc stays 0x10, if_id_pc/instr unchanged, id_ex_ctrl=0, id_ex_valid=0, stall_cnt=1. Next cycle pc=0x14.
- Branch during stall: branch_taken=1, branch_target=0x103, control_sel=1 in same cycle -> pc=0x100, if_id_instr=0x00000013, if_id_valid=0, id_ex_valid=0, flush_cnt=1, stall_cnt unchanged.
- PC wrap: force pc=0xFFFF_FFFC via branch_target, no stall -> next pc=0x0000_0000.
- Counter saturation with CNT_W=2: five consecutive control_sel=1 cycles -> stall_cnt=3 and holds.
- Async reset asserted mid-cycle during a stall with pc=0x40 -> pc=RESET_PC and all valids=0 before the next clock edge. BOOT cycle follows rst deassert.
